// File: rtl/alu_pm_pkg.sv
// rtl/alu_pm_pkg.sv - shared opcodes, power-mode encodings, FSM states and divide-ratio helper
// Purpose : common definitions for alu_pm_pipe and alu_pm_tick_gen.
// Ports   : none (package).
package alu_pm_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam logic [1:0] PM_DIV1 = 2'b00;
  localparam logic [1:0] PM_DIV2 = 2'b01;
  localparam logic [1:0] PM_DIV4 = 2'b10;
  localparam logic [1:0] PM_DIV8 = 2'b11;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } state_t;

  // Number of Clk cycles per Tick for a given power mode.
  function automatic logic [3:0] div_ratio(input logic [1:0] pm);
    case (pm)
      PM_DIV1: div_ratio = 4'd1;
      PM_DIV2: div_ratio = 4'd2;
      PM_DIV4: div_ratio = 4'd4;
      default: div_ratio = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/alu_pm_tick_gen.sv
// rtl/alu_pm_tick_gen.sv - clock-enable strobe generator driven by the power mode
// Purpose : produces o_tick once every 1/2/4/8 cycles; a power-mode change restarts
//           the divider so the cycle after the change always ticks.
// Ports   : i_clk        sole clock
//           i_rst_n      synchronous active-low reset
//           i_power_mode divide select (00 /1, 01 /2, 10 /4, 11 /8)
//           o_tick       enable strobe, high when the divider counter is 0
module alu_pm_tick_gen
  import alu_pm_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_power_mode,
  output logic       o_tick
);

  logic [1:0] r_mode;
  logic [2:0] r_cnt;
  logic [3:0] w_last;

  assign w_last = div_ratio(r_mode) - 4'd1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      // Capture the live mode so leaving reset does not look like a mode change.
      r_mode <= i_power_mode;
      r_cnt  <= 3'd0;
    end else begin
      r_mode <= i_power_mode;
      if (i_power_mode != r_mode) begin
        r_cnt <= 3'd0;
      end else if ({1'b0, r_cnt} == w_last) begin
        r_cnt <= 3'd0;
      end else begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign o_tick = (r_cnt == 3'd0);

endmodule

// File: rtl/alu_pm_pipe.sv
// rtl/alu_pm_pipe.sv - two-stage ALU with tick-based power modes and idle-sleep FSM
// Purpose : accepts an operation over valid/ready, returns result and flags after two
//           pipeline advances; sleeps after IDLE_TICKS consecutive idle Ticks.
// Ports   : i_clk, i_rst_n          clock, synchronous active-low reset
//           i_in_valid, o_in_ready  operation handshake (o_in_ready == advance)
//           i_a, i_b, i_opcode      operands and operation
//           i_power_mode            Tick divide select
//           o_out_valid, i_out_ready result handshake
//           o_result, o_cout, o_overflow, o_zero, o_err  result and flags
//           o_sleep                 FSM is in SLEEP
module alu_pm_pipe
  import alu_pm_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int IDLE_TICKS = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_opcode,
  input  logic [1:0]       i_power_mode,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_zero,
  output logic             o_err,
  output logic             o_sleep
);

  localparam int             IW        = $clog2(IDLE_TICKS + 1);
  localparam logic [IW-1:0]  IDLE_LAST = IW'(IDLE_TICKS - 1);
  localparam logic [IW-1:0]  IDLE_ONE  = IW'(1);
  localparam int             MSB       = WIDTH - 1;

  logic             w_tick;
  logic             w_advance;
  logic             w_xfer;
  logic             w_idle_tick;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idle_cnt;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [2:0]       r_s1_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_overflow;
  logic             r_zero;
  logic             r_err;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_cout;
  logic             w_ovf;
  logic             w_err;

  alu_pm_tick_gen u_tick_gen (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_power_mode (i_power_mode),
    .o_tick       (w_tick)
  );

  // The whole pipeline moves in lock-step; a held result blocks both stages.
  assign w_advance   = w_tick && (r_state == ST_ACTIVE) && (!r_out_valid || i_out_ready);
  assign w_xfer      = i_in_valid && w_advance;
  assign w_idle_tick = w_tick && (r_state == ST_ACTIVE) && !w_xfer && !r_s1_valid && !r_out_valid;

  // Stage-2 combinational ALU on the stage-1 registers.
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_cout = 1'b0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (r_s1_op)
      OP_ADD: begin
        w_sum  = {1'b0, r_s1_a} + {1'b0, r_s1_b};
        w_res  = w_sum[WIDTH-1:0];
        w_cout = w_sum[WIDTH];
        w_ovf  = (r_s1_a[MSB] == r_s1_b[MSB]) && (w_res[MSB] != r_s1_a[MSB]);
      end
      OP_SUB: begin
        w_sum  = {1'b0, r_s1_a} + {1'b0, ~r_s1_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res  = w_sum[WIDTH-1:0];
        // No carry out of A+~B+1 means A<B unsigned, i.e. a borrow.
        w_cout = ~w_sum[WIDTH];
        w_ovf  = (r_s1_a[MSB] != r_s1_b[MSB]) && (w_res[MSB] != r_s1_a[MSB]);
      end
      OP_AND: w_res = r_s1_a & r_s1_b;
      OP_OR:  w_res = r_s1_a | r_s1_b;
      OP_XOR: w_res = r_s1_a ^ r_s1_b;
      OP_NOT: w_res = ~r_s1_a;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(r_s1_a) < $signed(r_s1_b))};
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_op     <= OP_ADD;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_cout      <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
      r_err       <= 1'b0;
    end else if (w_advance) begin
      r_s1_valid <= i_in_valid;
      // Operand isolation: stage-1 operands only toggle for real operations.
      if (i_in_valid) begin
        r_s1_a  <= i_a;
        r_s1_b  <= i_b;
        r_s1_op <= i_opcode;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result   <= w_res;
        r_cout     <= w_cout;
        r_overflow <= w_ovf;
        r_zero     <= (w_res == '0);
        r_err      <= w_err;
      end else begin
        // Bubbles leave the output bus quiet rather than showing held operands.
        r_result   <= '0;
        r_cout     <= 1'b0;
        r_overflow <= 1'b0;
        r_zero     <= 1'b0;
        r_err      <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_ACTIVE;
      r_idle_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_ACTIVE: begin
          if (w_tick) begin
            r_idle_cnt <= w_idle_tick ? (r_idle_cnt + IDLE_ONE) : '0;
          end
        end
        ST_WAKE:  r_idle_cnt <= '0;
        default:  r_idle_cnt <= r_idle_cnt;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_ACTIVE: begin
        // A transfer on the would-be final idle Tick clears w_idle_tick, so no sleep.
        if (w_idle_tick && (r_idle_cnt == IDLE_LAST)) begin
          w_state_nxt = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (i_in_valid) begin
          w_state_nxt = ST_WAKE;
        end
      end
      default: w_state_nxt = ST_ACTIVE;
    endcase
  end

  assign o_in_ready  = w_advance;
  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_cout      = r_cout;
  assign o_overflow  = r_overflow;
  assign o_zero      = r_zero;
  assign o_err       = r_err;
  assign o_sleep     = (r_state == ST_SLEEP);

endmodule

// File: tb/tb_alu_pm_pipe.sv
// tb/tb_alu_pm_pipe.sv - self-checking bench for alu_pm_pipe
module tb_alu_pm_pipe;
  import alu_pm_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        e;
  } vec_t;

  localparam longint SMAX = 64'sh7FFFFFFF;
  localparam longint SMIN = -64'sh80000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic [2:0]  i_opcode;
  logic [1:0]  i_power_mode;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [31:0] o_result;
  logic        o_cout;
  logic        o_overflow;
  logic        o_zero;
  logic        o_err;
  logic        o_sleep;

  int   checks = 0;
  int   errors = 0;
  exp_t cur_exp;
  exp_t sb_q[$];
  logic rnd_done;
  vec_t vecs[13];

  always #5 clk = ~clk;

  alu_pm_pipe #(.WIDTH(32), .IDLE_TICKS(4)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_a          (i_a),
    .i_b          (i_b),
    .i_opcode     (i_opcode),
    .i_power_mode (i_power_mode),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_result     (o_result),
    .o_cout       (o_cout),
    .o_overflow   (o_overflow),
    .o_zero       (o_zero),
    .o_err        (o_err),
    .o_sleep      (o_sleep)
  );

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [32:0] s;
    longint      sa;
    longint      sb;
    longint      t;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        e.result = s[31:0];
        e.cout = s[32];
        t = sa + sb;
        e.ovf = (t > SMAX) || (t < SMIN);
      end
      OP_SUB: begin
        e.result = a - b;
        e.cout = (a < b);
        t = sa - sb;
        e.ovf = (t > SMAX) || (t < SMIN);
      end
      OP_AND: e.result = a & b;
      OP_OR:  e.result = a | b;
      OP_XOR: e.result = a ^ b;
      OP_NOT: e.result = ~a;
      OP_SLT: e.result = (sa < sb) ? 32'd1 : 32'd0;
      default: e.err = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input logic c, input logic v,
                              input logic z, input logic e);
    vec_t r;
    r.op = op; r.a = a; r.b = b; r.res = res; r.c = c; r.v = v; r.z = z; r.e = e;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Scoreboard: pops on each output transfer, pushes on each input transfer.
  task automatic monitor();
    exp_t got;
    exp_t want;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb_q.delete();
      end else begin
        if (o_out_valid && i_out_ready && o_in_ready) begin
          got = {o_result, o_cout, o_overflow, o_zero, o_err};
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got result=%h", o_result);
          end else begin
            want = sb_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL sb_result got=%h c%b v%b z%b e%b want=%h c%b v%b z%b e%b",
                       got.result, got.cout, got.ovf, got.zero, got.err,
                       want.result, want.cout, want.ovf, want.zero, want.err);
            end
          end
        end
        if (i_in_valid && o_in_ready) sb_q.push_back(cur_exp);
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int n;
    i_opcode   = op;
    i_a        = a;
    i_b        = b;
    cur_exp    = e;
    i_in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (o_in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got=no_ready want=ready");
        break;
      end
    end
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  initial begin
    int          n;
    int          pulses[$];
    int          cyc;
    int          cnt;
    logic        acc;
    logic [31:0] snap_r;
    logic [3:0]  snap_f;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; i_in_valid = 1'b0; i_a = '0; i_b = '0; i_opcode = OP_ADD;
    i_power_mode = PM_DIV1; i_out_ready = 1'b1; cur_exp = '0; rnd_done = 1'b0;

    vecs[0]  = mk(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1, 0);
    vecs[1]  = mk(OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1, 0, 0, 0);
    vecs[2]  = mk(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 0, 0);
    vecs[3]  = mk(OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0, 0);
    vecs[4]  = mk(OP_RSV, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 0, 1, 1);
    vecs[5]  = mk(OP_NOT, 32'h0F0F0F0F, 32'hFFFFFFFF, 32'hF0F0F0F0, 0, 0, 0, 0);
    vecs[6]  = mk(OP_AND, 32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 0, 0, 0, 0);
    vecs[7]  = mk(OP_OR,  32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0, 0);
    vecs[8]  = mk(OP_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 0, 0, 1, 0);
    vecs[9]  = mk(OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 0, 0);
    vecs[10] = mk(OP_SUB, 32'h00000003, 32'h00000003, 32'h00000000, 0, 0, 1, 0);
    vecs[11] = mk(OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 0, 0, 1, 0);
    vecs[12] = mk(OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 0, 0, 0, 0);

    fork monitor(); join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_cout", {31'b0, o_cout}, 32'd0);
    chk("rst_overflow", {31'b0, o_overflow}, 32'd0);
    chk("rst_zero", {31'b0, o_zero}, 32'd0);
    chk("rst_err", {31'b0, o_err}, 32'd0);
    chk("rst_sleep", {31'b0, o_sleep}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Table vectors, back-to-back in mode 00
    for (int i = 0; i < 13; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, vecs[i].e});
    end
    repeat (6) @(posedge clk); #1;

    // Backpressure across three back-to-back operations
    i_out_ready = 1'b0;
    fork
      begin
        send(OP_ADD, 32'd100, 32'd23, model(OP_ADD, 32'd100, 32'd23));
        send(OP_SUB, 32'd50, 32'd60, model(OP_SUB, 32'd50, 32'd60));
        send(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, model(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F));
      end
      begin
        n = 0;
        do begin @(negedge clk); n++; end while (!o_out_valid && n < 50);
        chk("bp_wait_valid", {31'b0, o_out_valid}, 32'd1);
        snap_r = o_result;
        snap_f = {o_cout, o_overflow, o_zero, o_err};
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_result_hold", o_result, snap_r);
          chk("bp_flags_hold", {28'b0, o_cout, o_overflow, o_zero, o_err}, {28'b0, snap_f});
          chk("bp_in_ready_low", {31'b0, o_in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        i_out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;
    chk("bp_drained", 32'(sb_q.size()), 32'd0);

    // Mode 10 pacing, then switch to 00
    i_power_mode = PM_DIV4;
    i_opcode = OP_ADD; i_a = 32'd0; i_b = 32'd1;
    cur_exp = model(OP_ADD, i_a, i_b);
    i_in_valid = 1'b1;
    cyc = 0;
    while (pulses.size() < 7 && cyc < 80) begin
      @(negedge clk);
      acc = o_in_ready;
      if (acc) pulses.push_back(cyc);
      cyc++;
      @(posedge clk); #1;
      if (acc) begin i_a = i_a + 32'd1; cur_exp = model(OP_ADD, i_a, i_b); end
    end
    chk("m10_pulse_count", 32'(pulses.size()), 32'd7);
    for (int i = 3; i < pulses.size(); i++) begin
      chk("m10_pulse_gap", 32'(pulses[i] - pulses[i-1]), 32'd4);
    end
    i_power_mode = PM_DIV1;
    @(negedge clk);
    chk("m00_change_cycle_ready", {31'b0, o_in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("m00_next_cycle_ready", {31'b0, o_in_ready}, 32'd1);
    @(posedge clk); #1;
    i_a = i_a + 32'd1; cur_exp = model(OP_ADD, i_a, i_b);
    @(negedge clk);
    chk("m00_every_cycle_ready", {31'b0, o_in_ready}, 32'd1);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (6) @(posedge clk); #1;

    // Random traffic in mode 01 with random backpressure
    i_power_mode = PM_DIV2;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rop = 3'($urandom_range(0, 7));
          ra = (i % 5 == 0) ? 32'h7FFFFFFF : $urandom;
          rb = (i % 7 == 0) ? 32'h80000000 : $urandom;
          send(rop, ra, rb, model(rop, ra, rb));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          i_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_out_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("rnd_drained", 32'(sb_q.size()), 32'd0);

    // Idle sleep and wake in mode 00
    i_power_mode = PM_DIV1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("sleep_after_idle", {31'b0, o_sleep}, (i == 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    i_opcode = OP_OR; i_a = 32'h00F0; i_b = 32'h0F00;
    cur_exp = model(OP_OR, i_a, i_b);
    i_in_valid = 1'b1;
    @(negedge clk);
    chk("sleep_in_ready", {31'b0, o_in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wake_sleep_low", {31'b0, o_sleep}, 32'd0);
    chk("wake_in_ready", {31'b0, o_in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("wake_then_ready", {31'b0, o_in_ready}, 32'd1);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("wake_drained", 32'(sb_q.size()), 32'd0);

    // Reset while the result is stalled and stage 1 is full
    i_out_ready = 1'b0;
    send(OP_ADD, 32'd7, 32'd8, model(OP_ADD, 32'd7, 32'd8));
    send(OP_NOT, 32'h0, 32'h0, model(OP_NOT, 32'h0, 32'h0));
    chk("rst_pre_valid", {31'b0, o_out_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(negedge clk);
    chk("rst2_out_valid", {31'b0, o_out_valid}, 32'd0);
    chk("rst2_result", o_result, 32'd0);
    chk("rst2_flags", {28'b0, o_cout, o_overflow, o_zero, o_err}, 32'd0);
    chk("rst2_sleep", {31'b0, o_sleep}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (o_out_valid) cnt++;
    end
    chk("rst2_no_stale", 32'(cnt), 32'd0);
    chk("final_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
